// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-level BIST engine: FSM states and
// the bit position of each logic function in masks and expected-value fields.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam int NFUNC = 8;

    localparam int FN_BUF  = 7;
    localparam int FN_NOT  = 6;
    localparam int FN_AND  = 5;
    localparam int FN_NAND = 4;
    localparam int FN_OR   = 3;
    localparam int FN_NOR  = 2;
    localparam int FN_XOR  = 1;
    localparam int FN_XNOR = 0;

endpackage

// File: rtl/gate_bist_lanes.sv
// Eight bitwise gate lanes evaluated combinationally from a pair of W-bit
// operands; these are the circuits under test.
module gate_lanes #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_buf,
    output logic [W-1:0] y_not,
    output logic [W-1:0] y_and,
    output logic [W-1:0] y_nand,
    output logic [W-1:0] y_or,
    output logic [W-1:0] y_nor,
    output logic [W-1:0] y_xor,
    output logic [W-1:0] y_xnor
);

    assign y_buf  = a;
    assign y_not  = ~a;
    assign y_and  = a & b;
    assign y_nand = ~(a & b);
    assign y_or   = a | b;
    assign y_nor  = ~(a | b);
    assign y_xor  = a ^ b;
    assign y_xnor = ~(a ^ b);

endmodule

// File: rtl/gate_bist.sv
// Vector-memory driven self test of the gate lanes: each stored vector is
// fetched, applied, allowed to settle, and checked against its expectations.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 136,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [10*W-1:0]            ld_data,
    input  logic [$clog2(DEPTH+1)-1:0] nvec,
    input  logic                       stop_on_fail,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH+1)-1:0] err_count,
    output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
    output logic [7:0]                 first_fail_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t                        state;
    logic [10*W-1:0]               mem [DEPTH];
    logic [10*W-1:0]               rd_data;
    logic [AW-1:0]                 idx;
    logic [CW-1:0]                 nvec_q;
    logic                          stop_q;
    logic [3:0]                    wait_cnt;
    logic [W-1:0]                  a_q;
    logic [W-1:0]                  b_q;
    logic [NFUNC-1:0][W-1:0]       exp_q;
    logic [NFUNC-1:0][W-1:0]       y;
    logic [NFUNC-1:0]              mask;
    logic                          fail;
    logic                          last;
    logic                          idle_like;

    gate_lanes #(.W(W)) u_lanes (
        .a      (a_q),
        .b      (b_q),
        .y_buf  (y[FN_BUF]),
        .y_not  (y[FN_NOT]),
        .y_and  (y[FN_AND]),
        .y_nand (y[FN_NAND]),
        .y_or   (y[FN_OR]),
        .y_nor  (y[FN_NOR]),
        .y_xor  (y[FN_XOR]),
        .y_xnor (y[FN_XNOR])
    );

    always_comb begin
        mask = '0;
        for (int f = 0; f < NFUNC; f++) begin
            mask[f] = (y[f] != exp_q[f]);
        end
    end

    assign fail      = |mask;
    assign last      = (CW'(idx) == nvec_q - CW'(1));
    assign idle_like = (state == IDLE) || (state == DONE);

    // Memory has no reset so loaded vectors survive a reset between runs.
    always_ff @(posedge clk) begin
        if (ld_en && idle_like) begin
            mem[ld_addr] <= ld_data;
        end
        if (state == FETCH) begin
            rd_data <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_mask <= '0;
            idx             <= '0;
            nvec_q          <= '0;
            stop_q          <= 1'b0;
            wait_cnt        <= '0;
            a_q             <= '0;
            b_q             <= '0;
            exp_q           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count       <= '0;
                        first_fail_idx  <= '0;
                        first_fail_mask <= '0;
                        idx             <= '0;
                        stop_q          <= stop_on_fail;
                        nvec_q          <= (nvec > CW'(DEPTH)) ? CW'(DEPTH) : nvec;
                        if (nvec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    a_q   <= rd_data[10*W-1 -: W];
                    b_q   <= rd_data[9*W-1 -: W];
                    exp_q <= rd_data[8*W-1:0];
                    if (SETTLE == 0) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(SETTLE - 1)) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (fail) begin
                        if (err_count != CW'(DEPTH)) begin
                            err_count <= err_count + CW'(1);
                        end
                        if (err_count == '0) begin
                            first_fail_idx  <= idx;
                            first_fail_mask <= mask;
                        end
                    end
                    if (last || (fail && stop_q)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !fail;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
